// File: rtl/melody_seq.sv
// Melody sequencer feeding the beep tone generator: walks a 16-entry note/duration
// table, producing per-note period counts with a silent gap between notes.
module melody_seq #(
  parameter logic [24:0] BEAT_CNT_MAX = 25'd24_999_999,
  parameter logic [24:0] GAP_CYCLES   = 25'd2_500_000,
  parameter logic [17:0] DO           = 18'd190839,
  parameter logic [17:0] RE           = 18'd170067,
  parameter logic [17:0] MI           = 18'd151514,
  parameter logic [17:0] FA           = 18'd143265,
  parameter logic [17:0] SO           = 18'd127551,
  parameter logic [17:0] LA           = 18'd113636,
  parameter logic [17:0] XI           = 18'd101215
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [17:0] note_period,
  output logic [16:0] note_half,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t      state_q, state_d;
  logic [24:0] cyc_cnt_q, cyc_cnt_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [17:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        load;
  logic [3:0]  load_idx;
  logic [2:0]  load_note;

  // Note field of the melody table: rising scale, rest, falling scale, long DO.
  function automatic logic [2:0] note_of(input logic [3:0] i);
    case (i)
      4'd0:    note_of = 3'd1;
      4'd1:    note_of = 3'd2;
      4'd2:    note_of = 3'd3;
      4'd3:    note_of = 3'd4;
      4'd4:    note_of = 3'd5;
      4'd5:    note_of = 3'd6;
      4'd6:    note_of = 3'd7;
      4'd7:    note_of = 3'd0;
      4'd8:    note_of = 3'd7;
      4'd9:    note_of = 3'd6;
      4'd10:   note_of = 3'd5;
      4'd11:   note_of = 3'd4;
      4'd12:   note_of = 3'd3;
      4'd13:   note_of = 3'd2;
      default: note_of = 3'd1;
    endcase
  endfunction

  function automatic logic [1:0] dur_of(input logic [3:0] i);
    dur_of = (i == 4'd15) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [17:0] period_of(input logic [2:0] n);
    case (n)
      3'd1:    period_of = DO;
      3'd2:    period_of = RE;
      3'd3:    period_of = MI;
      3'd4:    period_of = FA;
      3'd5:    period_of = SO;
      3'd6:    period_of = LA;
      3'd7:    period_of = XI;
      default: period_of = 18'd0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    beat_cnt_d = beat_cnt_q;
    idx_d      = idx_q;
    period_d   = period_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_idx   = 4'd0;
    load_note  = 3'd0;

    if (stop) begin
      state_d    = IDLE;
      cyc_cnt_d  = 25'd0;
      beat_cnt_d = 2'd0;
      idx_d      = 4'd0;
      period_d   = 18'd0;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            load     = 1'b1;
            load_idx = 4'd0;
          end
        end
        PLAY: begin
          if (cyc_cnt_q == BEAT_CNT_MAX) begin
            cyc_cnt_d = 25'd0;
            if (beat_cnt_q == dur_of(idx_q)) begin
              state_d    = GAP;
              beat_cnt_d = 2'd0;
              period_d   = 18'd0;
              valid_d    = 1'b0;
            end else begin
              beat_cnt_d = beat_cnt_q + 2'd1;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q + 25'd1;
          end
        end
        GAP: begin
          // cyc_cnt doubles as the gap counter; loop_en only matters on entry 15's last gap cycle
          if (cyc_cnt_q == GAP_CYCLES - 25'd1) begin
            if (idx_q != 4'd15) begin
              load     = 1'b1;
              load_idx = idx_q + 4'd1;
            end else if (loop_en) begin
              load     = 1'b1;
              load_idx = 4'd0;
            end else begin
              state_d   = IDLE;
              cyc_cnt_d = 25'd0;
              idx_d     = 4'd0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q + 25'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        load_note  = note_of(load_idx);
        state_d    = PLAY;
        idx_d      = load_idx;
        cyc_cnt_d  = 25'd0;
        beat_cnt_d = 2'd0;
        period_d   = period_of(load_note);
        valid_d    = (load_note != 3'd0);
        busy_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cyc_cnt_q  <= 25'd0;
      beat_cnt_q <= 2'd0;
      idx_q      <= 4'd0;
      period_q   <= 18'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      idx_q      <= idx_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note_period = period_q;
  assign note_half   = period_q[17:1];
  assign note_valid  = valid_q;
  assign note_idx    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
